// File: rtl/mux_sel_arb.sv
// mux_sel_arb: round-robin arbiter producing a registered select index for a downstream mux.
// Define MUX_SEL_ARB_TIMEOUT_EN to build the per-grant hold-limit timeout (HOLD_MAX cycles).
module mux_sel_arb #(
  parameter int SEL_WIDTH = 4,
  parameter int HOLD_MAX  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2**SEL_WIDTH-1:0] req_in,
  input  logic                    done_in,
  output logic [SEL_WIDTH-1:0]    sel_out,
  output logic [2**SEL_WIDTH-1:0] gnt_out,
  output logic                    gnt_vld_out
);
  // state | meaning
  // IDLE  | no grant active; gnt_out/gnt_vld_out low, sel_out keeps last index
  // GRANT | sel_out owns the mux; gnt_out = 1 << sel_out
  localparam int N = 2**SEL_WIDTH;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [SEL_WIDTH-1:0] ptr_q, ptr_d, sel_d, base, win_idx;
  logic [N-1:0]         gnt_d;
  logic                 win_found, timeout, release_evt;

`ifdef MUX_SEL_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(HOLD_MAX + 1);

  logic [CNT_W-1:0] hold_q, hold_d;
  logic             new_grant;

  assign timeout   = (hold_q == CNT_W'(HOLD_MAX));
  assign new_grant = (state_d == GRANT) && ((state_q == IDLE) || release_evt);

  // Counter can never pass HOLD_MAX: reaching it forces a release that reloads or clears it.
  always_comb begin
    hold_d = '0;
    if (new_grant)
      hold_d = CNT_W'(1);
    else if (state_d == GRANT)
      hold_d = hold_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hold_q <= '0;
    else     hold_q <= hold_d;
  end
`else
  assign timeout = 1'b0;
`endif

  assign release_evt = (state_q == GRANT) && (done_in || !req_in[sel_out] || timeout);

  // On release the search starts just past the grantee, giving it lowest priority.
  assign base = release_evt ? sel_out + SEL_WIDTH'(1) : ptr_q;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (!win_found && req_in[base + SEL_WIDTH'(i)]) begin
        win_found = 1'b1;
        win_idx   = base + SEL_WIDTH'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_out;
    gnt_d   = gnt_out;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = GRANT;
          sel_d   = win_idx;
          gnt_d   = N'(1) << win_idx;
        end
      end
      GRANT: begin
        if (release_evt) begin
          ptr_d = base;
          if (win_found) begin
            sel_d = win_idx;
            gnt_d = N'(1) << win_idx;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_out <= '0;
      gnt_out <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_out <= sel_d;
      gnt_out <= gnt_d;
    end
  end

  assign gnt_vld_out = (state_q == GRANT);

endmodule

// File: tb/tb_mux_sel_arb.sv
// Testbench for mux_sel_arb: directed scenarios plus randomized traffic against a reference model.
// Expectations follow MUX_SEL_ARB_TIMEOUT_EN the same way the design does.
module tb_mux_sel_arb;
  localparam int SEL_WIDTH = 4;
  localparam int HOLD_MAX  = 4;
  localparam int N         = 1 << SEL_WIDTH;
`ifdef MUX_SEL_ARB_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [N-1:0]         req_in = '0;
  logic                 done_in = 1'b0;
  logic [SEL_WIDTH-1:0] sel_out;
  logic [N-1:0]         gnt_out;
  logic                 gnt_vld_out;

  int checks = 0;
  int errors = 0;

  mux_sel_arb #(.SEL_WIDTH(SEL_WIDTH), .HOLD_MAX(HOLD_MAX)) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .done_in(done_in),
    .sel_out(sel_out), .gnt_out(gnt_out), .gnt_vld_out(gnt_vld_out)
  );

  always #5 clk = ~clk;

  // Reference model: who holds the grant, where the next search starts, and grant age.
  int m_sel = 0;
  int m_ptr = 0;
  int m_hold = 0;
  bit m_vld = 1'b0;

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    logic [2*N-1:0] dbl;
    dbl = {r, r} >> p;
    for (int k = 0; k < N; k++)
      if (dbl[k]) return (p + k) % N;
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin : ref_model
    int nxt;
    bit rel;
    if (rst) begin
      m_sel <= 0; m_ptr <= 0; m_hold <= 0; m_vld <= 1'b0;
    end else if (!m_vld) begin
      nxt = rr_pick(req_in, m_ptr);
      if (nxt >= 0) begin
        m_sel <= nxt; m_vld <= 1'b1; m_hold <= 1;
      end
    end else begin
      rel = done_in || !req_in[m_sel] || (TIMEOUT_ON && m_hold >= HOLD_MAX);
      if (rel) begin
        m_ptr <= (m_sel + 1) % N;
        nxt = rr_pick(req_in, (m_sel + 1) % N);
        if (nxt >= 0) begin
          m_sel <= nxt; m_hold <= 1;
        end else begin
          m_vld <= 1'b0; m_hold <= 0;
        end
      end else begin
        m_hold <= m_hold + 1;
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; req_in = '0; done_in = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (sel_out !== '0 || gnt_out !== '0 || gnt_vld_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: sel=%0d gnt=%h vld=%b, expected sel=0 gnt=0 vld=0", sel_out, gnt_out, gnt_vld_out);
    end
    rst = 1'b0; req_in = N'(16'h0020);
    @(negedge clk);
    checks++;
    if (sel_out !== SEL_WIDTH'(5) || gnt_out !== N'(16'h0020) || gnt_vld_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_grant: sel=%0d gnt=%h vld=%b, expected sel=5 gnt=0020 vld=1", sel_out, gnt_out, gnt_vld_out);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (sel_out !== '0 || gnt_out !== '0 || gnt_vld_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: sel=%0d gnt=%h vld=%b, expected sel=0 gnt=0 vld=0", sel_out, gnt_out, gnt_vld_out);
    end
    @(negedge clk);
    rst = 1'b0; req_in = N'(16'h0001);
    @(negedge clk);
    checks++;
    if (sel_out !== '0 || gnt_out !== N'(16'h0001) || gnt_vld_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_regrant: sel=%0d gnt=%h vld=%b, expected sel=0 gnt=0001 vld=1", sel_out, gnt_out, gnt_vld_out);
    end
  endtask

  task automatic test_rotation();
    int exp;
    req_in = '1;
    for (int k = 1; k <= N; k++) begin
      exp = k % N;
      done_in = 1'b1;
      @(negedge clk);
      done_in = 1'b0;
      for (int h = 0; h < 2; h++) begin
        checks++;
        if (sel_out !== SEL_WIDTH'(exp) || gnt_out !== (N'(1) << exp) || gnt_vld_out !== 1'b1) begin
          errors++;
          $display("FAIL rotation step %0d/%0d: sel=%0d gnt=%h vld=%b, expected sel=%0d vld=1", k, h, sel_out, gnt_out, gnt_vld_out, exp);
        end
        if (h == 0) @(negedge clk);
      end
    end
  endtask

  task automatic test_priority_skip();
    int exp_seq [3] = '{3, 0, 2};
    logic [N-1:0] req_seq [3];
    req_seq[0] = N'(16'h0008);
    req_seq[1] = N'(16'h0005);
    req_seq[2] = N'(16'h0005);
    for (int s = 0; s < 3; s++) begin
      req_in = req_seq[s]; done_in = 1'b1;
      @(negedge clk);
      done_in = 1'b0;
      checks++;
      if (sel_out !== SEL_WIDTH'(exp_seq[s]) || gnt_vld_out !== 1'b1) begin
        errors++;
        $display("FAIL priority_skip step %0d: sel=%0d vld=%b, expected sel=%0d vld=1", s, sel_out, gnt_vld_out, exp_seq[s]);
      end
    end
  endtask

  task automatic test_request_drop();
    req_in = N'(16'h0080);
    @(negedge clk);
    checks++;
    if (sel_out !== SEL_WIDTH'(7) || gnt_vld_out !== 1'b1) begin
      errors++;
      $display("FAIL drop_grant7: sel=%0d vld=%b, expected sel=7 vld=1", sel_out, gnt_vld_out);
    end
    req_in = '0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (sel_out !== SEL_WIDTH'(7) || gnt_out !== '0 || gnt_vld_out !== 1'b0) begin
        errors++;
        $display("FAIL drop_idle cycle %0d: sel=%0d gnt=%h vld=%b, expected sel=7 gnt=0 vld=0", c, sel_out, gnt_out, gnt_vld_out);
      end
      done_in = (c == 0);
    end
    done_in = 1'b0; req_in = N'(16'h0080);
    @(negedge clk);
    checks++;
    if (sel_out !== SEL_WIDTH'(7) || gnt_out !== N'(16'h0080) || gnt_vld_out !== 1'b1) begin
      errors++;
      $display("FAIL drop_regrant: sel=%0d gnt=%h vld=%b, expected sel=7 gnt=0080 vld=1", sel_out, gnt_out, gnt_vld_out);
    end
  endtask

  task automatic test_timeout();
    int exp;
    req_in = N'(16'h0003);
    for (int g = 0; g < 3 * HOLD_MAX; g++) begin
      @(negedge clk);
      exp = TIMEOUT_ON ? (g / HOLD_MAX) % 2 : 0;
      checks++;
      if (sel_out !== SEL_WIDTH'(exp) || gnt_vld_out !== 1'b1) begin
        errors++;
        $display("FAIL timeout cycle %0d: sel=%0d vld=%b, expected sel=%0d vld=1", g, sel_out, gnt_vld_out, exp);
      end
    end
  endtask

  task automatic test_sole_requester();
    req_in = N'(16'h0100);
    for (int p = 0; p < 6; p++) begin
      @(negedge clk);
      done_in = 1'b0;
      checks++;
      if (sel_out !== SEL_WIDTH'(8) || gnt_out !== N'(16'h0100) || gnt_vld_out !== 1'b1) begin
        errors++;
        $display("FAIL sole_requester cycle %0d: sel=%0d gnt=%h vld=%b, expected sel=8 gnt=0100 vld=1", p, sel_out, gnt_out, gnt_vld_out);
      end
      done_in = p[0];
    end
    done_in = 1'b0;
  endtask

  task automatic test_random();
    logic [N-1:0] r;
    logic [N-1:0] exp_gnt;
    r = req_in;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      exp_gnt = m_vld ? (N'(1) << m_sel) : '0;
      checks++;
      if (sel_out !== SEL_WIDTH'(m_sel) || gnt_vld_out !== m_vld || gnt_out !== exp_gnt) begin
        errors++;
        $display("FAIL random cycle %0d: sel=%0d vld=%b gnt=%h, expected sel=%0d vld=%b gnt=%h", c, sel_out, gnt_vld_out, gnt_out, m_sel, m_vld, exp_gnt);
      end
      rst = 1'b0;
      if ($urandom_range(0, 99) < 30) begin
        case ($urandom_range(0, 3))
          0: r = '0;
          1: r = N'(1) << $urandom_range(0, N - 1);
          2: r = N'($urandom);
          default: r = '1;
        endcase
      end
      req_in  = r;
      done_in = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 149) == 0) rst = 1'b1;
    end
    rst = 1'b0; done_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected normal completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_rotation();
    test_priority_skip();
    test_request_drop();
    test_timeout();
    test_sole_requester();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_sel_arb.md
# mux_sel_arb

Round-robin select arbiter that sits directly upstream of the parameterised `mux` data selector. It collects request lines from 2**SEL_WIDTH sources, grants one at a time with rotating priority, and drives the registered select index into the mux `sel_in` port. The grant is held until the grantee signals completion, drops its request, or, when configured, exceeds a hold limit.

## Interface
- `SEL_WIDTH`, default 4: select index width; number of requesters is N = 2**SEL_WIDTH.
- `HOLD_MAX`, default 16: maximum granted cycles per grant when the timeout is compiled in; legal range is 1 or more.

- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst`, input, 1: reset; asynchronous and active-high.
- `req_in`, input, N: per-source request, level-sensitive.
- `done_in`, input, 1: grantee finished its transfer; single-cycle pulse.
- `sel_out`, output, SEL_WIDTH: granted index; connects to mux `sel_in`.
- `gnt_out`, output, N: one-hot grant; all zero when idle.
- `gnt_vld_out`, output, 1: a grant is active.

## Operation
- Reset values: `sel_out` = 0, `gnt_out` = 0, `gnt_vld_out` = 0. Internal state: pointer `ptr` = 0, state IDLE, hold counter = 0.
- The FSM has two states:
  - IDLE: no grant is active.
  - GRANT: `gnt_vld_out` = 1, with `gnt_out` = 1 << `sel_out`.
- Arbitration function: choose the first set bit of `req_in` scanning `ptr`, `ptr`+1, … mod N. The search wraps past N-1 to 0.
- In IDLE:
  - If `req_in` != 0, arbitrate, register the winner into `sel_out`/`gnt_out`, and enter GRANT.
  - Otherwise remain in IDLE.
- In GRANT, a release event is any of:
  - `done_in` = 1;
  - `req_in[sel_out]` = 0;
  - timeout, when compiled in.
- On release:
  - `ptr` ← `sel_out` + 1 (mod N).
  - Arbitrate `req_in` in the same cycle using the new pointer, so the releasing source has lowest priority.
  - If a winner exists, register it and stay in GRANT (back-to-back, no bubble).
  - Otherwise clear `gnt_out`/`gnt_vld_out` and enter IDLE.
- A releasing source that still requests and is the only requester is re-granted.
- `sel_out` holds its last granted value in IDLE; only the grant outputs clear.
- `done_in` in IDLE is ignored.
- Simultaneous release causes (for example `done_in` plus timeout) count as one release.
- `rst` asserted mid-grant forces all outputs and state to their reset values immediately, without waiting for a clock edge.

## Timing
- Request-to-grant latency is 1 cycle:
  - `req_in` becomes nonzero in cycle n while in IDLE.
  - Grant outputs are valid in cycle n+1.
- Release-to-next-grant latency is 1 cycle:
  - A release event occurs in cycle m.
  - The new grant, or idle outputs, appear in cycle m+1.
- Mux data for the new grantee is valid in the same cycle as `sel_out`, because the mux is combinational.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Hold counter:
  - Loads 1 in the first granted cycle and increments each further granted cycle.
  - Reloads 1 on every new grant, including back-to-back grants.
  - Width is $clog2(HOLD_MAX+1).

## Configuration
- Macro `MUX_SEL_ARB_TIMEOUT_EN`.
- Defined: the counter and timeout are built. When the counter equals `HOLD_MAX` with no other release, a forced release occurs in that cycle, so one grant lasts at most `HOLD_MAX` cycles. With `HOLD_MAX` = 1, every grant lasts exactly one cycle.
- Undefined: the counter is not built and `HOLD_MAX` is unused. Grants persist until `done_in` or the grantee's request drops.

## Test plan
- Reset: assert `rst` asynchronously mid-grant with `sel_out` = 5 -> `gnt_out` = 0, `gnt_vld_out` = 0, `sel_out` = 0 before the next edge; after release of reset, `req_in` = 0x0001 -> grant to 0 one cycle later.
- Rotation: `req_in` = 0xFFFF held and `done_in` pulsed every 2 cycles -> `sel_out` sequence 0, 1, 2, …, 15, 0 with no idle cycle between grants.
- Priority skip: grant on 3, `req_in` = 0x0005, `done_in` pulse -> next `sel_out` = 0 (wrap past 15); then a `done_in` pulse -> `sel_out` = 2.
- Request drop: grant on 7, `req_in[7]` drops with no other requests -> `gnt_vld_out` = 0 next cycle, `sel_out` stays 7; `req_in` = 0x0080 again -> re-grant 7 one cycle later.
- Timeout (macro defined, `HOLD_MAX` = 4): `req_in` = 0x0003, no `done_in` -> `sel_out` alternates 0, 1 every 4 cycles. With the macro undefined, the same stimulus keeps `sel_out` = 0 indefinitely.
- Sole requester: `req_in` = 0x0100 with `done_in` pulsed -> `sel_out` stays 8, `gnt_vld_out` stays 1, and the hold counter reloads.
